// File: rtl/cpu_req_gen.sv
// cpu_req_gen: CPU-side traffic generator for the cache subsystem.
// Issues a write sweep, a read sweep, or a write sweep followed by a
// self-checking read-back over the Req_CPU/Ready_Cache handshake.
// Mismatches are counted and a stalled cache aborts the run with a timeout.

module cpu_req_gen #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                NUM_REQ     = 16,
   parameter logic [ADDR_W-1:0] START_ADDR  = '0,
   parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(4),
   parameter logic [DATA_W-1:0] START_DATA  = DATA_W'(64),
   parameter int                MODE        = 2,
   parameter logic [1:0]        INS_TYPE    = 2'b00,
   parameter int                TIMEOUT     = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              Ready_Cache,
   input  logic [DATA_W-1:0] data_in,
   output logic              Req_CPU,
   output logic              Wr_CPU,
   output logic [ADDR_W-1:0] A_CPU,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        Ins_Type,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   // The index only has to reach NUM_REQ-1; the wait counter only TIMEOUT-1,
   // because the abort fires on the edge that would make it reach TIMEOUT.
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam bit CHECK_READS = (MODE == 2);
   localparam bit READ_FIRST  = (MODE == 1);

   typedef enum logic [1:0] {
      IDLE,
      WR_SWEEP,
      RD_SWEEP,
      FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    index_q, index_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
   logic                timeout_q, timeout_d;
   logic [15:0]         errCnt_q, errCnt_d;
   logic [ADDR_W-1:0]   firstErrAddr_q, firstErrAddr_d;

   logic reqActive;
   logic accept;
   logic lastAccept;
   logic timeoutHit;
   logic readMismatch;

   // A request is outstanding in either sweep; the handshake and the stall
   // abort are both derived from it and the cache's ready.
   always_comb begin
      reqActive    = (state_q == WR_SWEEP) || (state_q == RD_SWEEP);
      accept       = reqActive && Ready_Cache;
      lastAccept   = accept && (index_q == LAST_IDX);
      timeoutHit   = reqActive && !Ready_Cache && (waitCnt_q == WAIT_LAST);
      readMismatch = CHECK_READS && accept && (state_q == RD_SWEEP)
                     && (data_in != data_q);
   end

   // State register; reset parks the sequencer in IDLE and drops any request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a stall abort always wins over a pending acceptance,
   // and only the checked mode chains the write sweep into a read sweep.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ_FIRST ? RD_SWEEP : WR_SWEEP;
            end
         end
         WR_SWEEP: begin
            if (timeoutHit) begin
               state_d = FINISH;
            end else if (lastAccept) begin
               state_d = CHECK_READS ? RD_SWEEP : FINISH;
            end
         end
         RD_SWEEP: begin
            if (timeoutHit || lastAccept) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake and status outputs decoded purely from the current state.
   always_comb begin
      Req_CPU  = reqActive;
      Wr_CPU   = (state_q == WR_SWEEP);
      busy     = reqActive;
      done     = (state_q == FINISH);
      Ins_Type = reqActive ? INS_TYPE : 2'b00;
   end

   // Datapath next values: the address/data/index walk, the wait counter and
   // the read-back bookkeeping. The expected read value equals data_q because
   // the data register is reloaded to START_DATA before the read sweep.
   always_comb begin
      index_d        = index_q;
      addr_d         = addr_q;
      data_d         = data_q;
      waitCnt_d      = waitCnt_q;
      timeout_d      = timeout_q;
      errCnt_d       = errCnt_q;
      firstErrAddr_d = firstErrAddr_q;

      if (state_q == IDLE) begin
         if (start) begin
            index_d        = '0;
            addr_d         = START_ADDR;
            data_d         = START_DATA;
            waitCnt_d      = '0;
            timeout_d      = 1'b0;
            errCnt_d       = '0;
            firstErrAddr_d = '0;
         end
      end else if (accept) begin
         waitCnt_d = '0;
         if (lastAccept && (state_q == WR_SWEEP) && CHECK_READS) begin
            index_d = '0;
            addr_d  = START_ADDR;
            data_d  = START_DATA;
         end else begin
            index_d = index_q + 1'b1;
            addr_d  = addr_q + ADDR_STRIDE;
            data_d  = data_q + 1'b1;
         end
         if (readMismatch) begin
            if (errCnt_q == '0) begin
               firstErrAddr_d = addr_q;
            end
            if (errCnt_q != 16'hFFFF) begin
               errCnt_d = errCnt_q + 16'd1;
            end
         end
      end else if (reqActive) begin
         if (timeoutHit) begin
            timeout_d = 1'b1;
            waitCnt_d = '0;
         end else begin
            waitCnt_d = waitCnt_q + 1'b1;
         end
      end
   end

   // Datapath registers; everything returns to zero on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         index_q        <= '0;
         addr_q         <= '0;
         data_q         <= '0;
         waitCnt_q      <= '0;
         timeout_q      <= 1'b0;
         errCnt_q       <= '0;
         firstErrAddr_q <= '0;
      end else begin
         index_q        <= index_d;
         addr_q         <= addr_d;
         data_q         <= data_d;
         waitCnt_q      <= waitCnt_d;
         timeout_q      <= timeout_d;
         errCnt_q       <= errCnt_d;
         firstErrAddr_q <= firstErrAddr_d;
      end
   end

   assign A_CPU          = addr_q;
   assign data_out       = data_q;
   assign timeout        = timeout_q;
   assign err_cnt        = errCnt_q;
   assign first_err_addr = firstErrAddr_q;

endmodule
